// File: rtl/out_display_ctrl.sv
// out_display_ctrl
//  Drives a multiplexed common-anode 7-segment display from the OUT register.
//  A sequential double-dabble engine (one shift per clk) converts i_data to
//  BCD whenever it differs from the last converted value. The scanner walks
//  the digits round-robin and shows only completed results. Not gated by
//  clk_en, so the display stays live while the CPU is halted.
// Ports
//  clk     system clock, rising edge
//  rst     synchronous reset, active-high
//  i_data  binary value to display
//  o_busy  conversion in progress
//  o_bcd   last completed BCD result, nibble 0 = least significant digit
//  o_an    digit enables, active-low, one-hot-low, o_an[0] = least significant
//  o_seg   segments, active-low, {g,f,e,d,c,b,a}
module out_display_ctrl #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_busy,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_an,
  output logic [6:0]            o_seg
);

  localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam int RW = ($clog2(REFRESH_DIV) > 0) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = ($clog2(DIGITS) > 0) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_snap, r_bin;
  logic [4*DIGITS-1:0] r_work, r_bcd, w_adj, w_work_nxt;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic [RW-1:0]       r_ref;
  logic [IW-1:0]       r_idx;
  logic [DIGITS-1:0]   r_an, w_an, w_lz;
  logic [6:0]          r_seg, w_seg;
  logic [3:0]          w_nib;
  logic                w_start, w_last, w_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign w_start = (r_state == S_IDLE) && (i_data != r_snap);
  assign w_last  = (r_state == S_CONV) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_CONV;
      S_CONV:  if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 on every nibble >= 5, then shift {work,bin} left by one.
  always_comb begin
    w_adj = r_work;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
    w_work_nxt = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
  end

  // o_bcd is written only on the final shift, so it never shows a partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_busy <= 1'b0;
    end else if (w_start) begin
      r_snap <= i_data;
      r_bin  <= i_data;
      r_work <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_state == S_CONV) begin
      r_work <= w_work_nxt;
      r_bin  <= {r_bin[WIDTH-2:0], 1'b0};
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_bcd  <= w_work_nxt;
        r_busy <= 1'b0;
      end
    end
  end

  // w_lz[i]: nibbles i..DIGITS-1 of the displayed result are all zero.
  always_comb begin
    w_lz    = '1;
    w_nib   = 4'h0;
    w_an    = '1;
    w_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      for (int unsigned k = i; k < DIGITS; k++) begin
        if (r_bcd[4*k +: 4] != 4'h0) w_lz[i] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib   = r_bcd[4*i +: 4];
        w_an[i] = 1'b0;
        w_blank = (BLANK_LZ != 0) && (i > 0) && w_lz[i];
      end
    end
    w_seg = w_blank ? 7'b1111111 : seg_decode(w_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= '1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      if (r_ref == REF_LAST) begin
        r_ref <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_ref <= r_ref + 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_bcd  = r_bcd;
  assign o_an   = r_an;
  assign o_seg  = r_seg;

endmodule

// File: tb/tb_out_display_ctrl.sv
// tb_out_display_ctrl
//  Directed bench for out_display_ctrl with WIDTH=16, DIGITS=5, REFRESH_DIV=4.
module tb_out_display_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] i_data;
  logic        o_busy;
  logic [19:0] o_bcd;
  logic [4:0]  o_an;
  logic [6:0]  o_seg;

  int unsigned n_checks;
  int unsigned n_fail;

  // Expected segments per digit, packed {d4,d3,d2,d1,d0}.
  localparam logic [34:0] SEG_ZERO  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [34:0] SEG_1234  = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [34:0] SEG_65535 = {7'h02, 7'h12, 7'h12, 7'h30, 7'h12};
  localparam logic [34:0] SEG_42    = {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24};

  out_display_ctrl #(
    .WIDTH       (16),
    .DIGITS      (5),
    .REFRESH_DIV (4),
    .BLANK_LZ    (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .o_busy (o_busy),
    .o_bcd  (o_bcd),
    .o_an   (o_an),
    .o_seg  (o_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input string tag, input logic [15:0] v);
    i_data = v;
    step();
    chk({tag, "_busy_hi"}, {31'd0, o_busy}, 32'd1);
    repeat (16) step();
    chk({tag, "_busy_lo"}, {31'd0, o_busy}, 32'd0);
  endtask

  // One full scan round: every active digit must show its expected pattern.
  task automatic scan_verify(input string tag, input logic [34:0] exp);
    int unsigned idx;
    step();
    for (int c = 0; c < 20; c++) begin
      chk({tag, "_an1hot"}, $countones(~o_an), 32'd1);
      idx = 0;
      for (int unsigned i = 0; i < 5; i++) if (!o_an[i]) idx = i;
      chk({tag, "_seg"}, {25'd0, o_seg}, {25'd0, exp[7*idx +: 7]});
      step();
    end
  endtask

  initial begin
    logic [4:0]  an_exp;
    int unsigned d;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    i_data   = 16'd0;

    // 1: reset, value 0 held
    step();
    step();
    chk("t1_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("t1_rst_bcd", {12'd0, o_bcd}, 32'd0);
    chk("t1_rst_an", {27'd0, o_an}, 32'h1F);
    chk("t1_rst_seg", {25'd0, o_seg}, 32'h7F);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t1_busy", {31'd0, o_busy}, 32'd0);
      chk("t1_bcd", {12'd0, o_bcd}, 32'd0);
    end
    scan_verify("t1", SEG_ZERO);

    // 2: 0 -> 1234, latency and busy width
    i_data = 16'd1234;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("t2_busy_hi", {31'd0, o_busy}, 32'd1);
      if (i == 15) chk("t2_bcd_early", {12'd0, o_bcd}, 32'd0);
      step();
    end
    chk("t2_busy_lo", {31'd0, o_busy}, 32'd0);
    chk("t2_bcd", {12'd0, o_bcd}, 32'h01234);
    scan_verify("t2", SEG_1234);

    // 3: full-scale value
    convert("t3", 16'd65535);
    chk("t3_bcd", {12'd0, o_bcd}, 32'h65535);
    scan_verify("t3", SEG_65535);

    // 4: input change mid-conversion is deferred until IDLE
    i_data = 16'd999;
    step();
    repeat (4) step();
    i_data = 16'd42;
    repeat (11) step();
    chk("t4_bcd_hold", {12'd0, o_bcd}, 32'h65535);
    step();
    chk("t4_bcd_999", {12'd0, o_bcd}, 32'h00999);
    chk("t4_idle_gap", {31'd0, o_busy}, 32'd0);
    step();
    chk("t4_restart", {31'd0, o_busy}, 32'd1);
    repeat (15) step();
    chk("t4_bcd_mid", {12'd0, o_bcd}, 32'h00999);
    chk("t4_busy_mid", {31'd0, o_busy}, 32'd1);
    step();
    chk("t4_bcd_42", {12'd0, o_bcd}, 32'h00042);
    chk("t4_busy_lo", {31'd0, o_busy}, 32'd0);

    // 6: reset mid-conversion aborts, then restarts on the held value
    i_data = 16'd500;
    step();
    chk("t6_busy_hi", {31'd0, o_busy}, 32'd1);
    repeat (6) step();
    rst = 1'b1;
    step();
    chk("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("t6_rst_bcd", {12'd0, o_bcd}, 32'd0);
    chk("t6_rst_an", {27'd0, o_an}, 32'h1F);
    chk("t6_rst_seg", {25'd0, o_seg}, 32'h7F);
    rst = 1'b0;
    step();
    chk("t6_restart", {31'd0, o_busy}, 32'd1);
    repeat (15) step();
    chk("t6_bcd_early", {12'd0, o_bcd}, 32'd0);
    step();
    chk("t6_bcd", {12'd0, o_bcd}, 32'h00500);
    chk("t6_busy_lo", {31'd0, o_busy}, 32'd0);

    // 5: scan order and timing measured from a reset edge, value 42
    rst    = 1'b1;
    i_data = 16'd42;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
      d      = ((k - 1) / 4) % 5;
      an_exp = ~(5'b00001 << d);
      chk("t5_an", {27'd0, o_an}, {27'd0, an_exp});
      if (k == 17) chk("t5_bcd", {12'd0, o_bcd}, 32'h00042);
      if (k >= 18) chk("t5_seg", {25'd0, o_seg}, {25'd0, SEG_42[7*d +: 7]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
